// File: rtl/uart_fw_loader.sv
// UART (8N1) firmware loader: receives a framed, checksummed image, streams it
// word by word into program memory and holds the CPU in reset until it is valid.
module uart_fw_loader #(
  parameter int          CLK_DIV        = 217,
  parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
  parameter int          MAX_WORDS      = 8192,
  parameter int          TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rx,
  output logic        progmem_wen,
  output logic [31:0] progmem_waddr,
  output logic [31:0] progmem_wdata,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int BCW = $clog2(CLK_DIV);
  localparam int GCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLK_DIV / 2 - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_t;

  rx_state_t      rx_state;
  logic           rx_meta, rx_sync, rx_prev;
  logic [BCW-1:0] baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     rx_shift;
  logic           rx_valid, rx_ferr;

  state_t         state;
  logic [1:0]     byte_cnt;
  logic [23:0]    byte_buf;
  logic [29:0]    word_idx, last_idx;
  logic [7:0]     csum;
  logic [GCW-1:0] gap_cnt;
  logic [31:0]    full_word;
  logic [7:0]     csum_next;

  // Bytes arrive little-endian: the byte in rx_shift is always the top one.
  assign full_word = {rx_shift, byte_buf};
  assign csum_next = csum + rx_shift;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make the synchronizer collapse to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so they can never stick high.
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_BITS;  // glitch: silently drop
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            rx_valid <= rx_sync;
            rx_ferr  <= !rx_sync;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      byte_buf      <= '0;
      word_idx      <= '0;
      last_idx      <= '0;
      csum          <= '0;
      gap_cnt       <= '0;
      progmem_wen   <= 1'b0;
      progmem_waddr <= '0;
      progmem_wdata <= '0;
      cpu_resetn    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      progmem_wen <= 1'b0;
      done        <= 1'b0;

      if (state == IDLE || rx_valid) gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST)  gap_cnt <= gap_cnt + 1'b1;

      // Framing error or inter-byte timeout kills the frame; CPU stays held.
      if (state != IDLE && (rx_ferr || (!rx_valid && gap_cnt == GAP_LAST))) begin
        state <= IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (!err) cpu_resetn <= 1'b1;
            if (rx_ferr) begin
              err <= 1'b1;
            end else if (rx_valid && rx_shift == 8'hA5) begin
              state      <= LEN;
              busy       <= 1'b1;
              cpu_resetn <= 1'b0;
              err        <= 1'b0;
              byte_cnt   <= '0;
              csum       <= '0;
            end
          end
          LEN: begin
            if (rx_valid) begin
              csum     <= csum_next;
              byte_cnt <= byte_cnt + 1'b1;
              byte_buf <= {rx_shift, byte_buf[23:8]};
              if (byte_cnt == 2'd3) begin
                if (full_word == 32'd0 || full_word > 32'(MAX_WORDS)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  err   <= 1'b1;
                end else begin
                  state    <= DATA;
                  word_idx <= '0;
                  last_idx <= 30'(full_word - 32'd1);
                end
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              csum     <= csum_next;
              byte_cnt <= byte_cnt + 1'b1;
              byte_buf <= {rx_shift, byte_buf[23:8]};
              if (byte_cnt == 2'd3) begin
                progmem_wen   <= 1'b1;
                progmem_waddr <= BASE_ADDR + {word_idx, 2'b00};
                progmem_wdata <= full_word;
                word_idx      <= word_idx + 1'b1;
                if (word_idx == last_idx) state <= CSUM;
              end
            end
          end
          CSUM: begin
            if (rx_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (csum_next == 8'h00) begin
                done       <= 1'b1;
                cpu_resetn <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_fw_loader.sv
// Directed bench for uart_fw_loader: drives UART frames bit by bit and checks
// writes, done/err/busy and the CPU reset hold against hand-derived values.
module tb_uart_fw_loader;
  localparam int          CLK_DIV        = 8;
  localparam logic [31:0] BASE_ADDR      = 32'h0010_0000;
  localparam int          MAX_WORDS      = 4;
  localparam int          TIMEOUT_CYCLES = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_rx;
  logic        progmem_wen;
  logic [31:0] progmem_waddr;
  logic [31:0] progmem_wdata;
  logic        cpu_resetn;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  uart_fw_loader #(
    .CLK_DIV(CLK_DIV),
    .BASE_ADDR(BASE_ADDR),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ser_rx(ser_rx),
    .progmem_wen(progmem_wen),
    .progmem_waddr(progmem_waddr),
    .progmem_wdata(progmem_wdata),
    .cpu_resetn(cpu_resetn),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (progmem_wen) begin
      wr_addr.push_back(progmem_waddr);
      wr_data.push_back(progmem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ser_rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    ser_rx = stop_bit;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    ser_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  // Checksum byte chosen so LEN + payload + CSUM sums to 0 mod 256, plus csum_delta.
  task automatic send_frame(input logic [31:0] words[$], input logic [7:0] csum_delta);
    logic [7:0]  s;
    logic [31:0] len;
    s   = 8'h00;
    len = 32'(words.size());
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      s = s + len[8*i +: 8];
      send_byte(len[8*i +: 8], 1'b1);
    end
    foreach (words[w]) begin
      for (int i = 0; i < 4; i++) begin
        s = s + words[w][8*i +: 8];
        send_byte(words[w][8*i +: 8], 1'b1);
      end
    end
    send_byte(8'h00 - s + csum_delta, 1'b1);
  endtask

  initial begin
    int wb;
    int db;
    logic [31:0] words[$];

    rst    = 1'b1;
    ser_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wen", 32'(progmem_wen), 32'd0);
    check("rst_waddr", progmem_waddr, 32'd0);
    check("rst_wdata", progmem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_cpu_resetn", 32'(cpu_resetn), 32'd1);

    // Two-word load with a correct checksum.
    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    wb = wr_addr.size(); db = done_cnt;
    send_frame(words, 8'h00);
    repeat (3) @(negedge clk);
    check("ok_nwr", 32'(wr_addr.size() - wb), 32'd2);
    check("ok_addr0", wr_addr[wb], 32'h0010_0000);
    check("ok_data0", wr_data[wb], 32'h1234_5678);
    check("ok_addr1", wr_addr[wb+1], 32'h0010_0004);
    check("ok_data1", wr_data[wb+1], 32'hDEAD_BEEF);
    check("ok_done", 32'(done_cnt - db), 32'd1);
    check("ok_cpu_resetn", 32'(cpu_resetn), 32'd1);
    check("ok_err", 32'(err), 32'd0);
    check("ok_busy", 32'(busy), 32'd0);
    check("ok_hold_waddr", progmem_waddr, 32'h0010_0004);
    check("ok_hold_wdata", progmem_wdata, 32'hDEAD_BEEF);

    // Same frame, checksum off by one, then recovery with a valid frame.
    wb = wr_addr.size(); db = done_cnt;
    send_frame(words, 8'h01);
    repeat (3) @(negedge clk);
    check("bad_nwr", 32'(wr_addr.size() - wb), 32'd2);
    check("bad_data1", wr_data[wb+1], 32'hDEAD_BEEF);
    check("bad_done", 32'(done_cnt - db), 32'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_cpu_resetn", 32'(cpu_resetn), 32'd0);
    db = done_cnt;
    send_frame(words, 8'h00);
    repeat (3) @(negedge clk);
    check("rec_err", 32'(err), 32'd0);
    check("rec_cpu_resetn", 32'(cpu_resetn), 32'd1);
    check("rec_done", 32'(done_cnt - db), 32'd1);

    // Noise before the sync byte is ignored.
    wb = wr_addr.size(); db = done_cnt;
    send_list('{8'h00, 8'hFF, 8'h3C});
    @(negedge clk);
    check("noise_nwr", 32'(wr_addr.size() - wb), 32'd0);
    check("noise_busy", 32'(busy), 32'd0);
    send_frame(words, 8'h00);
    repeat (3) @(negedge clk);
    check("noise_then_nwr", 32'(wr_addr.size() - wb), 32'd2);
    check("noise_then_done", 32'(done_cnt - db), 32'd1);

    // 0xA5 inside the payload is data, not a restart.
    words = '{32'hA5A5_A5A5};
    wb = wr_addr.size(); db = done_cnt;
    send_frame(words, 8'h00);
    repeat (3) @(negedge clk);
    check("a5_nwr", 32'(wr_addr.size() - wb), 32'd1);
    check("a5_data", wr_data[wb], 32'hA5A5_A5A5);
    check("a5_done", 32'(done_cnt - db), 32'd1);

    // LEN == MAX_WORDS is the largest accepted frame.
    words = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'hCAFE_F00D};
    wb = wr_addr.size(); db = done_cnt;
    send_frame(words, 8'h00);
    repeat (3) @(negedge clk);
    check("max_nwr", 32'(wr_addr.size() - wb), 32'd4);
    check("max_addr3", wr_addr[wb+3], 32'h0010_000C);
    check("max_data3", wr_data[wb+3], 32'hCAFE_F00D);
    check("max_done", 32'(done_cnt - db), 32'd1);

    // LEN == 0 and LEN == MAX_WORDS+1 are rejected; trailing bytes are ignored.
    wb = wr_addr.size();
    send_list('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00});
    repeat (2) @(negedge clk);
    check("len0_err", 32'(err), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_cpu_resetn", 32'(cpu_resetn), 32'd0);
    send_list('{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    repeat (2) @(negedge clk);
    check("lenmax_err", 32'(err), 32'd1);
    check("lenmax_busy", 32'(busy), 32'd0);
    check("len_nwr", 32'(wr_addr.size() - wb), 32'd0);

    // Inter-byte timeout mid-word.
    wb = wr_addr.size();
    send_list('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22});
    @(negedge clk);
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_err_before", 32'(err), 32'd0);
    repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("to_nwr", 32'(wr_addr.size() - wb), 32'd0);

    // Stop bit forced low.
    words = '{32'h0BAD_F00D};
    send_frame(words, 8'h00);
    repeat (2) @(negedge clk);
    check("ferr_pre_err", 32'(err), 32'd0);
    wb = wr_addr.size();
    send_byte(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    check("ferr_err", 32'(err), 32'd1);
    check("ferr_nwr", 32'(wr_addr.size() - wb), 32'd0);

    // Reset mid-DATA aborts the frame.
    send_list('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33});
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    wb = wr_addr.size();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("mid_rst_waddr", progmem_waddr, 32'd0);
    check("mid_rst_wdata", progmem_wdata, 32'd0);
    rst = 1'b0;
    send_byte(8'h44, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_nwr", 32'(wr_addr.size() - wb), 32'd0);
    check("mid_cpu_resetn", 32'(cpu_resetn), 32'd1);
    check("mid_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
